// File: rtl/multi_stat_counter.sv
// Multi-channel periodic event counter: per-channel window qualification, counting
// and PPS latching, followed by a registered channel-select readout.

module msc_channel #(
    parameter int COUNTER_WIDTH = 20,
    parameter int VALUE_WIDTH   = 16,
    parameter int SATURATE      = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   count_i,
    input  logic                   count_ce_i,
    input  logic                   ch_en_i,
    input  logic                   pps_i,
    output logic [VALUE_WIDTH-1:0] lat_val,
    output logic                   lat_ovf
);
    logic [COUNTER_WIDTH-1:0] cnt;
    logic                     seen;
    logic                     ovf_run;
    logic                     hit;
    logic                     at_max;

    // An event coincident with the window strobe still belongs to the closing window.
    assign hit    = count_ce_i & (seen | count_i);
    assign at_max = &cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt     <= '0;
            seen    <= 1'b0;
            ovf_run <= 1'b0;
            lat_val <= '0;
            lat_ovf <= 1'b0;
        end else begin
            if (count_ce_i)
                seen <= 1'b0;
            else if (count_i)
                seen <= 1'b1;

            if (pps_i) begin
                lat_val <= cnt[COUNTER_WIDTH-1 -: VALUE_WIDTH];
                lat_ovf <= ovf_run | (hit & ch_en_i & at_max);
                cnt     <= (hit & ch_en_i) ? COUNTER_WIDTH'(1) : '0;
                ovf_run <= 1'b0;
            end else if (ch_en_i && hit) begin
                if (at_max) begin
                    ovf_run <= 1'b1;
                    if (SATURATE == 0)
                        cnt <= '0;
                end else begin
                    cnt <= cnt + COUNTER_WIDTH'(1);
                end
            end
        end
    end
endmodule

module multi_stat_counter #(
    parameter int NUM_CH        = 8,
    parameter int COUNTER_WIDTH = 20,
    parameter int VALUE_WIDTH   = 16,
    parameter int SEL_WIDTH     = 3,
    parameter int SATURATE      = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NUM_CH-1:0]      count_i,
    input  logic                   count_ce_i,
    input  logic [NUM_CH-1:0]      ch_en_i,
    input  logic                   pps_i,
    input  logic [SEL_WIDTH-1:0]   sel_i,
    output logic [VALUE_WIDTH-1:0] value_o,
    output logic                   ovf_o,
    output logic                   latched_o
);
    localparam int NSEL = 2 ** SEL_WIDTH;

    logic [NUM_CH-1:0][VALUE_WIDTH-1:0] lat_val;
    logic [NUM_CH-1:0]                  lat_ovf;
    logic [NSEL-1:0][VALUE_WIDTH-1:0]   val_pad;
    logic [NSEL-1:0]                    ovf_pad;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        msc_channel #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .VALUE_WIDTH   (VALUE_WIDTH),
            .SATURATE      (SATURATE)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .count_i    (count_i[g]),
            .count_ce_i (count_ce_i),
            .ch_en_i    (ch_en_i[g]),
            .pps_i      (pps_i),
            .lat_val    (lat_val[g]),
            .lat_ovf    (lat_ovf[g])
        );
    end

    // Select space beyond NUM_CH is padded with zeros so the mux needs no range compare.
    for (genvar g = 0; g < NSEL; g++) begin : g_pad
        if (g < NUM_CH) begin : g_live
            assign val_pad[g] = lat_val[g];
            assign ovf_pad[g] = lat_ovf[g];
        end else begin : g_zero
            assign val_pad[g] = '0;
            assign ovf_pad[g] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            value_o   <= '0;
            ovf_o     <= 1'b0;
            latched_o <= 1'b0;
        end else begin
            value_o   <= val_pad[sel_i];
            ovf_o     <= ovf_pad[sel_i];
            latched_o <= pps_i;
        end
    end
endmodule

// File: tb/tb_multi_stat_counter.sv
// Five parameterisations driven in parallel and checked against a hit-count model
// every cycle, with literal expectations pinning the key scenarios.

module tb_multi_stat_counter;
    localparam int NI = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  count = '0;
    logic [7:0]  ch_en = 8'hFF;
    logic        ce = 1'b0;
    logic        pps = 1'b0;
    logic [2:0]  sel = '0;
    logic [15:0] v0, v1, v4;
    logic [3:0]  v2, v3;
    logic [NI-1:0] ovf, lat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_stat_counter #(.NUM_CH(8), .COUNTER_WIDTH(20), .VALUE_WIDTH(16), .SEL_WIDTH(3), .SATURATE(1)) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .count_i(count), .count_ce_i(ce), .ch_en_i(ch_en),
        .pps_i(pps), .sel_i(sel), .value_o(v0), .ovf_o(ovf[0]), .latched_o(lat[0]));
    multi_stat_counter #(.NUM_CH(8), .COUNTER_WIDTH(16), .VALUE_WIDTH(16), .SEL_WIDTH(3), .SATURATE(1)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .count_i(count), .count_ce_i(ce), .ch_en_i(ch_en),
        .pps_i(pps), .sel_i(sel), .value_o(v1), .ovf_o(ovf[1]), .latched_o(lat[1]));
    multi_stat_counter #(.NUM_CH(8), .COUNTER_WIDTH(4), .VALUE_WIDTH(4), .SEL_WIDTH(3), .SATURATE(1)) u2 (
        .clk_i(clk), .rst_n_i(rst_n), .count_i(count), .count_ce_i(ce), .ch_en_i(ch_en),
        .pps_i(pps), .sel_i(sel), .value_o(v2), .ovf_o(ovf[2]), .latched_o(lat[2]));
    multi_stat_counter #(.NUM_CH(8), .COUNTER_WIDTH(4), .VALUE_WIDTH(4), .SEL_WIDTH(3), .SATURATE(0)) u3 (
        .clk_i(clk), .rst_n_i(rst_n), .count_i(count), .count_ce_i(ce), .ch_en_i(ch_en),
        .pps_i(pps), .sel_i(sel), .value_o(v3), .ovf_o(ovf[3]), .latched_o(lat[3]));
    multi_stat_counter #(.NUM_CH(6), .COUNTER_WIDTH(16), .VALUE_WIDTH(16), .SEL_WIDTH(3), .SATURATE(1)) u4 (
        .clk_i(clk), .rst_n_i(rst_n), .count_i(count[5:0]), .count_ce_i(ce), .ch_en_i(ch_en[5:0]),
        .pps_i(pps), .sel_i(sel), .value_o(v4), .ovf_o(ovf[4]), .latched_o(lat[4]));

    function automatic int cw_of(input int i);
        case (i)
            0:       return 20;
            1, 4:    return 16;
            default: return 4;
        endcase
    endfunction

    function automatic int vw_of(input int i);
        return (i == 2 || i == 3) ? 4 : 16;
    endfunction

    function automatic bit sat_of(input int i);
        return (i == 3) ? 1'b0 : 1'b1;
    endfunction

    function automatic int nch_of(input int i);
        return (i == 4) ? 6 : 8;
    endfunction

    // Reported value of a period with h credited hits for a given counter geometry.
    function automatic int conv(input int h, input int cw, input int vw, input bit sat);
        longint mx, v;
        mx = (longint'(1) << cw) - 1;
        v  = sat ? ((h > mx) ? mx : longint'(h)) : (longint'(h) % (mx + 1));
        return int'(v >> (cw - vw));
    endfunction

    function automatic int dval(input int i);
        case (i)
            0:       return int'(v0);
            1:       return int'(v1);
            2:       return int'(v2);
            3:       return int'(v3);
            default: return int'(v4);
        endcase
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] @%0t: got %0d expected %0d", nm, idx, $time, act, exp);
        end
    endtask

    // Model: each channel accumulates credited hits per period as a plain integer.
    int  h_cnt [8];
    int  lat_h [8];
    bit  lat_ph[8];
    bit  seen_m[8];
    int  ev    [NI];
    bit  eo    [NI];
    bit  el    [NI];
    bit  mhit;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 8; c++) begin
                h_cnt[c] = 0; lat_h[c] = 0; lat_ph[c] = 0; seen_m[c] = 0;
            end
            for (int i = 0; i < NI; i++) begin
                ev[i] = 0; eo[i] = 0; el[i] = 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                el[i] = pps;
                if (int'(sel) < nch_of(i)) begin
                    ev[i] = conv(lat_h[sel], cw_of(i), vw_of(i), sat_of(i));
                    eo[i] = (longint'(lat_h[sel]) + lat_ph[sel]) > ((longint'(1) << cw_of(i)) - 1);
                end else begin
                    ev[i] = 0;
                    eo[i] = 0;
                end
            end
            for (int c = 0; c < 8; c++) begin
                mhit = ce && (seen_m[c] || count[c]);
                if (pps) begin
                    lat_h[c]  = h_cnt[c];
                    lat_ph[c] = mhit && ch_en[c];
                    h_cnt[c]  = (mhit && ch_en[c]) ? 1 : 0;
                end else if (mhit && ch_en[c]) begin
                    h_cnt[c]++;
                end
                if (ce) seen_m[c] = 1'b0;
                else if (count[c]) seen_m[c] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk("value_o", i, dval(i), ev[i]);
            chk("ovf_o", i, int'(ovf[i]), int'(eo[i]));
            chk("latched_o", i, int'(lat[i]), int'(el[i]));
        end
    end

    task automatic tick(input logic [7:0] c, input logic e, input logic p);
        count = c;
        ce    = e;
        pps   = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_value", 0, int'(v0), 0);
        chk("rst_ovf", 0, int'(ovf[0]), 0);
        chk("rst_latched", 0, int'(lat[0]), 0);
        rst_n = 1'b1;

        // Five single-event windows on ch0.
        for (int w = 0; w < 5; w++) begin
            tick(8'h01, 1'b0, 1'b0);
            tick(8'h00, 1'b1, 1'b0);
        end
        tick(8'h00, 1'b0, 1'b1);
        chk("lit_latched", 0, int'(lat[0]), 1);
        tick(8'h00, 1'b0, 1'b0);
        chk("lit_prescaled", 0, int'(v0), 0);
        chk("lit_fullwidth", 1, int'(v1), 5);
        chk("lit_fullwidth_ovf", 1, int'(ovf[1]), 0);

        // Events only in the ce cycle; ch3 disabled.
        ch_en = 8'hF7;
        for (int w = 0; w < 3; w++) begin
            tick(8'h00, 1'b0, 1'b0);
            tick(8'h0C, 1'b1, 1'b0);
        end
        tick(8'h00, 1'b0, 1'b1);
        sel = 3'd2;
        tick(8'h00, 1'b0, 1'b0);
        chk("lit_coincident", 1, int'(v1), 3);
        sel = 3'd3;
        tick(8'h00, 1'b0, 1'b0);
        chk("lit_disabled", 1, int'(v1), 0);
        ch_en = 8'hFF;

        // 20 hits into a 4-bit counter, then a 2-hit period.
        sel = 3'd1;
        for (int w = 0; w < 20; w++) tick(8'h02, 1'b1, 1'b0);
        tick(8'h00, 1'b0, 1'b1);
        tick(8'h00, 1'b0, 1'b0);
        chk("lit_sat_val", 2, int'(v2), 15);
        chk("lit_sat_ovf", 2, int'(ovf[2]), 1);
        chk("lit_wrap_val", 3, int'(v3), 4);
        chk("lit_wrap_ovf", 3, int'(ovf[3]), 1);
        for (int w = 0; w < 2; w++) tick(8'h02, 1'b1, 1'b0);
        tick(8'h00, 1'b0, 1'b1);
        tick(8'h00, 1'b0, 1'b0);
        chk("lit_sat_next", 2, int'(v2), 2);
        chk("lit_sat_next_ovf", 2, int'(ovf[2]), 0);
        chk("lit_wrap_next", 3, int'(v3), 2);

        // pps coincident with a hit after 7 hits on ch4.
        sel = 3'd4;
        for (int w = 0; w < 7; w++) tick(8'h10, 1'b1, 1'b0);
        tick(8'h10, 1'b1, 1'b1);
        tick(8'h00, 1'b0, 1'b0);
        chk("lit_pps_hit", 1, int'(v1), 7);
        tick(8'h00, 1'b0, 1'b1);
        tick(8'h00, 1'b0, 1'b0);
        chk("lit_pps_credit", 1, int'(v1), 1);

        // Back-to-back pps.
        tick(8'h00, 1'b0, 1'b1);
        chk("lit_b2b_1", 0, int'(lat[0]), 1);
        tick(8'h00, 1'b0, 1'b1);
        chk("lit_b2b_2", 0, int'(lat[0]), 1);
        tick(8'h00, 1'b0, 1'b0);
        chk("lit_b2b_end", 0, int'(lat[0]), 0);

        // Channel n receives n hits, then sweep the select.
        for (int k = 1; k < 8; k++) begin
            m = 8'hFF << k;
            tick(m, 1'b1, 1'b0);
        end
        tick(8'h00, 1'b0, 1'b1);
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick(8'h00, 1'b0, 1'b0);
            chk("lit_sweep", 1, int'(v1), s);
            if (s >= 6) chk("lit_sweep_oob", 4, int'(v4), 0);
        end

        // Asynchronous reset mid-period.
        for (int w = 0; w < 3; w++) tick(8'hFF, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("lit_async_val", 1, int'(v1), 0);
        chk("lit_async_val4", 4, int'(v4), 0);
        chk("lit_async_ovf", 2, int'(ovf[2]), 0);
        chk("lit_async_lat", 0, int'(lat[0]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(8'h00, 1'b0, 1'b1);
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick(8'h00, 1'b0, 1'b0);
            chk("lit_post_rst", 1, int'(v1), 0);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
